// File: rtl/sprite_draw_arbiter.sv
// sprite_draw_arbiter: round-robin sharing of the single sprite-draw engine.
// A winning requester's operands are latched into eng_*. The engine is then
// started and followed through its busy period, and a done pulse goes back to
// the owner when the draw ends or when the engine never starts.
//
// Handshakes:
//   req/grant       : req is a level. The requester holds req and its operands
//                     stable until it sees grant. grant is a one-cycle pulse,
//                     and the operands are captured on that same edge.
//   eng_start/done  : eng_start rises together with grant. It stays high until
//                     the engine is seen busy (eng_done==0), or until the start
//                     timeout expires. It is always low again before the engine
//                     can return to idle, so a finished draw is never re-triggered.
module sprite_draw_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int X_W           = 8,
    parameter int Y_W           = 7,
    parameter int ADDR_W        = 15,
    parameter int START_TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*X_W-1:0]    req_x,
    input  logic [NUM_REQ*Y_W-1:0]    req_y,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      hold,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      eng_start,
    output logic [X_W-1:0]            eng_x,
    output logic [Y_W-1:0]            eng_y,
    output logic [ADDR_W-1:0]         eng_base_addr,
    input  logic                      eng_done,
    output logic                      busy,
    output logic [2:0]                owner,
    output logic                      err,
    output logic [1:0]                debugState
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DRAW  = 2'd2
    } stateT;

    stateT                stateQ, stateD;
    logic [IDX_W-1:0]     rrPtr, rrPtrD;
    logic [TMR_W-1:0]     timerQ, timerD;
    logic [IDX_W-1:0]     winner;
    logic                 found;
    int                   idx;

    logic [NUM_REQ-1:0]   grantD, doneD;
    logic                 engStartD, busyD, errD;
    logic [X_W-1:0]       engXD;
    logic [Y_W-1:0]       engYD;
    logic [ADDR_W-1:0]    engAddrD;
    logic [2:0]           ownerD;

    assign debugState = stateQ;

    // Round-robin search: first set req after the last winner, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rrPtr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        stateD    = stateQ;
        rrPtrD    = rrPtr;
        timerD    = timerQ;
        grantD    = '0;
        doneD     = '0;
        engStartD = eng_start;
        engXD     = eng_x;
        engYD     = eng_y;
        engAddrD  = eng_base_addr;
        busyD     = busy;
        ownerD    = owner;
        errD      = err;
        case (stateQ)
            IDLE: begin
                if (!hold && found) begin
                    grantD[winner] = 1'b1;
                    engXD          = req_x[winner*X_W +: X_W];
                    engYD          = req_y[winner*Y_W +: Y_W];
                    engAddrD       = req_addr[winner*ADDR_W +: ADDR_W];
                    ownerD         = 3'(winner);
                    rrPtrD         = winner;
                    engStartD      = 1'b1;
                    busyD          = 1'b1;
                    timerD         = '0;
                    stateD         = START;
                end
            end
            START: begin
                if (!eng_done) begin
                    engStartD = 1'b0;
                    stateD    = DRAW;
                end else if (timerQ == TMR_W'(START_TIMEOUT - 1)) begin
                    // Engine never left idle: release it and report to the owner.
                    engStartD     = 1'b0;
                    errD          = 1'b1;
                    doneD[rrPtr]  = 1'b1;
                    busyD         = 1'b0;
                    stateD        = IDLE;
                end else begin
                    timerD = timerQ + TMR_W'(1);
                end
            end
            DRAW: begin
                if (eng_done) begin
                    doneD[rrPtr] = 1'b1;
                    busyD        = 1'b0;
                    stateD       = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // State and output registers; reset clears everything and parks the pointer
    // on the last requester so requester 0 wins first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ        <= IDLE;
            rrPtr         <= IDX_W'(NUM_REQ - 1);
            timerQ        <= '0;
            grant         <= '0;
            done          <= '0;
            eng_start     <= 1'b0;
            eng_x         <= '0;
            eng_y         <= '0;
            eng_base_addr <= '0;
            busy          <= 1'b0;
            owner         <= '0;
            err           <= 1'b0;
        end else begin
            stateQ        <= stateD;
            rrPtr         <= rrPtrD;
            timerQ        <= timerD;
            grant         <= grantD;
            done          <= doneD;
            eng_start     <= engStartD;
            eng_x         <= engXD;
            eng_y         <= engYD;
            eng_base_addr <= engAddrD;
            busy          <= busyD;
            owner         <= ownerD;
            err           <= errD;
        end
    end
endmodule

// File: tb/tb_sprite_draw_arbiter.sv
// Testbench for sprite_draw_arbiter: behavioural draw engine, grant/done
// scoreboard and one task per scenario.
`timescale 1ns/1ps
module tb_sprite_draw_arbiter;
    localparam int NUM_REQ = 4;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int ADDR_W  = 15;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*X_W-1:0]    reqX;
    logic [NUM_REQ*Y_W-1:0]    reqY;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr;
    logic                      hold;
    logic [NUM_REQ-1:0]        grant, done;
    logic                      engStart, engDone, busy, err;
    logic [X_W-1:0]            engX;
    logic [Y_W-1:0]            engY;
    logic [ADDR_W-1:0]         engBase;
    logic [2:0]                owner;
    logic [1:0]                debugState;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [NUM_REQ-1:0] expGrantQ[$];
    logic [NUM_REQ-1:0] expDoneQ[$];

    sprite_draw_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .req_x(reqX), .req_y(reqY),
        .req_addr(reqAddr), .hold(hold), .grant(grant), .done(done),
        .eng_start(engStart), .eng_x(engX), .eng_y(engY), .eng_base_addr(engBase),
        .eng_done(engDone), .busy(busy), .owner(owner), .err(err),
        .debugState(debugState)
    );

    // Clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    // Behavioural draw engine: leaves idle one edge after seeing start.
    int drawLen   = 50;
    bit stuckIdle = 1'b0;
    int engCnt    = 0;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            engDone <= 1'b1;
            engCnt  <= 0;
        end else if (engDone) begin
            if (engStart && !stuckIdle) begin
                engDone <= 1'b0;
                engCnt  <= drawLen - 1;
            end
        end else if (engCnt == 0) begin
            engDone <= 1'b1;
        end else begin
            engCnt <= engCnt - 1;
        end
    end

    // Scoreboard: every grant/done pulse must match the head of its queue.
    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            if (grant !== '0) begin
                checks++;
                if (expGrantQ.size() == 0) begin
                    errors++; $display("FAIL sb_grant: got %b want none", grant);
                end else if (grant !== expGrantQ[0]) begin
                    errors++; $display("FAIL sb_grant: got %b want %b", grant, expGrantQ[0]);
                    void'(expGrantQ.pop_front());
                end else void'(expGrantQ.pop_front());
            end
            if (done !== '0) begin
                checks++;
                if (expDoneQ.size() == 0) begin
                    errors++; $display("FAIL sb_done: got %b want none", done);
                end else if (done !== expDoneQ[0]) begin
                    errors++; $display("FAIL sb_done: got %b want %b", done, expDoneQ[0]);
                    void'(expDoneQ.pop_front());
                end else void'(expDoneQ.pop_front());
            end
        end
    end

    task automatic setLane(input int i, input int x, input int y, input int a);
        reqX[i*X_W +: X_W]          = X_W'(x);
        reqY[i*Y_W +: Y_W]          = Y_W'(y);
        reqAddr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic waitFor(input bit forDone, input int maxCycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clock);
            if (forDone ? (done !== '0) : (grant !== '0)) seen = 1'b1;
        end
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1; req = '0; hold = 1'b0;
        repeat (3) @(negedge clock);
        expGrantQ.delete(); expDoneQ.delete();
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; hold = 1'b0; reqX = '0; reqY = '0; reqAddr = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({grant, done, engStart, busy, err, owner, engX, engY, engBase} !== '0) begin
            errors++; $display("FAIL reset_outputs: got grant=%b done=%b start=%b busy=%b err=%b owner=%0d want all 0",
                               grant, done, engStart, busy, err, owner);
        end
        checks++;
        if (debugState !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", debugState); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        bit seen;
        int startCnt;
        drawLen = 7200;
        setLane(0, 10, 20, 0);
        expGrantQ.push_back(4'b0001); expDoneQ.push_back(4'b0001);
        req = 4'b0001;
        waitFor(1'b0, 5, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t1_grant: got none want 0001"); end
        checks++;
        if (engX !== 8'd10 || engY !== 7'd20 || engBase !== 15'd0) begin
            errors++; $display("FAIL t1_operands: got x=%0d y=%0d a=%0d want 10 20 0", engX, engY, engBase);
        end
        checks++;
        if (owner !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL t1_owner_busy: got owner=%0d busy=%b want 0 1", owner, busy);
        end
        req = '0;
        startCnt = engStart ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 8000 && !seen; i++) begin
            @(negedge clock);
            if (engStart) startCnt++;
            if (done !== '0) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL t1_done: got none want 0001"); end
        checks++; if (startCnt != 2) begin errors++; $display("FAIL t1_start_len: got %0d want 2", startCnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after: got %b want 0", busy); end
        @(negedge clock);
        checks++; if (done !== '0) begin errors++; $display("FAIL t1_done_pulse: got %b want 0000", done); end
    endtask

    task automatic test_round_robin();
        bit seen;
        int nGrant, lastDone;
        resetDut();
        drawLen = 50;
        for (int i = 0; i < NUM_REQ; i++) setLane(i, 40 + i, 50 + i, 1000 * i);
        for (int i = 0; i < 5; i++) begin
            expGrantQ.push_back(NUM_REQ'(1 << (i % NUM_REQ)));
            expDoneQ.push_back(NUM_REQ'(1 << (i % NUM_REQ)));
        end
        req = 4'b1111;
        nGrant = 0; lastDone = -100;
        for (int i = 0; i < 1000 && nGrant < 5; i++) begin
            @(negedge clock);
            if (done !== '0) lastDone = cycle;
            if (grant !== '0) begin
                if (nGrant > 0) begin
                    checks++;
                    if (cycle - lastDone != 1) begin
                        errors++; $display("FAIL t2_gap: got %0d want 1", cycle - lastDone);
                    end
                end
                checks++;
                if (engX !== X_W'(40 + nGrant % NUM_REQ)) begin
                    errors++; $display("FAIL t2_eng_x: got %0d want %0d", engX, 40 + nGrant % NUM_REQ);
                end
                nGrant++;
                if (nGrant == 5) req = '0;
            end
        end
        checks++; if (nGrant != 5) begin errors++; $display("FAIL t2_grant_count: got %0d want 5", nGrant); end
        waitFor(1'b1, 200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t2_last_done: got none want 0001"); end
    endtask

    task automatic test_hold();
        bit seen;
        int grantSeen;
        setLane(2, 77, 33, 12345);
        hold = 1'b1;
        req = 4'b0100;
        grantSeen = 0;
        repeat (100) begin
            @(negedge clock);
            if (grant !== '0) grantSeen++;
        end
        checks++; if (grantSeen != 0) begin errors++; $display("FAIL t3_hold_grants: got %0d want 0", grantSeen); end
        expGrantQ.push_back(4'b0100); expDoneQ.push_back(4'b0100);
        hold = 1'b0;
        @(negedge clock);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t3_grant: got %b want 0100", grant); end
        checks++;
        if (engX !== 8'd77 || engY !== 7'd33 || engBase !== 15'd12345) begin
            errors++; $display("FAIL t3_operands: got x=%0d y=%0d a=%0d want 77 33 12345", engX, engY, engBase);
        end
        req = '0;
        waitFor(1'b1, 200, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t3_done: got none want 0100"); end
    endtask

    task automatic test_timeout();
        bit seen;
        int gCycle;
        stuckIdle = 1'b1;
        drawLen = 20;
        setLane(0, 5, 6, 7);
        expGrantQ.push_back(4'b0001); expDoneQ.push_back(4'b0001);
        req = 4'b0001;
        waitFor(1'b0, 5, seen);
        gCycle = cycle;
        req = '0;
        checks++; if (!seen) begin errors++; $display("FAIL t4_grant: got none want 0001"); end
        waitFor(1'b1, 40, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t4_done: got none want 0001"); end
        checks++; if (cycle - gCycle != 15) begin errors++; $display("FAIL t4_abort_time: got %0d want 15", cycle - gCycle); end
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || engStart !== 1'b0) begin
            errors++; $display("FAIL t4_abort_flags: got err=%b busy=%b start=%b want 1 0 0", err, busy, engStart);
        end
        stuckIdle = 1'b0;
        expGrantQ.push_back(4'b0010); expDoneQ.push_back(4'b0010);
        req = 4'b0010;
        waitFor(1'b0, 5, seen);
        req = '0;
        checks++; if (!seen) begin errors++; $display("FAIL t4_regrant: got none want 0010"); end
        waitFor(1'b1, 100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t4_redone: got none want 0010"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid_draw();
        bit seen;
        resetDut();
        drawLen = 200;
        setLane(1, 90, 91, 92);
        expGrantQ.push_back(4'b0010);
        req = 4'b0010;
        waitFor(1'b0, 5, seen);
        req = '0;
        checks++; if (!seen) begin errors++; $display("FAIL t5_grant: got none want 0010"); end
        repeat (10) @(negedge clock);
        checks++; if (debugState !== 2'd2) begin errors++; $display("FAIL t5_in_draw: got %0d want 2", debugState); end
        reset = 1'b1;
        #1;
        checks++;
        if ({grant, done, engStart, busy, err, owner, engX, engY, engBase, debugState} !== '0) begin
            errors++; $display("FAIL t5_reset_now: got start=%b busy=%b owner=%0d x=%0d state=%0d want all 0",
                               engStart, busy, owner, engX, debugState);
        end
        @(negedge clock);
        reset = 1'b0;
        expDoneQ.delete();
        expGrantQ.push_back(4'b0001); expGrantQ.push_back(4'b0010);
        expDoneQ.push_back(4'b0001);  expDoneQ.push_back(4'b0010);
        req = 4'b0011;
        waitFor(1'b0, 5, seen);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t5_first_after_reset: got %b want 0001", grant); end
        req = 4'b0010;
        waitFor(1'b0, 300, seen);
        req = '0;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t5_second: got %b want 0010", grant); end
        waitFor(1'b1, 300, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t5_done: got none want 0010"); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        int doneCycle;
        drawLen = 30;
        expGrantQ.push_back(4'b0001); expGrantQ.push_back(4'b0100); expGrantQ.push_back(4'b0001);
        expDoneQ.push_back(4'b0001);  expDoneQ.push_back(4'b0100);  expDoneQ.push_back(4'b0001);
        req = 4'b0001;
        waitFor(1'b0, 5, seen);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t6_first: got %b want 0001", grant); end
        req = 4'b0101;
        waitFor(1'b1, 100, seen);
        doneCycle = cycle;
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL t6_done0: got %b want 0001", done); end
        waitFor(1'b0, 5, seen);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL t6_fair: got %b want 0100", grant); end
        checks++; if (cycle - doneCycle != 1) begin errors++; $display("FAIL t6_gap: got %0d want 1", cycle - doneCycle); end
        req = 4'b0001;
        waitFor(1'b0, 100, seen);
        req = '0;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL t6_regain: got %b want 0001", grant); end
        waitFor(1'b1, 100, seen);
        checks++; if (!seen) begin errors++; $display("FAIL t6_done: got none want 0001"); end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #900us;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_timeout();
        test_reset_mid_draw();
        test_back_to_back();
        repeat (5) @(negedge clock);
        checks++;
        if (expGrantQ.size() != 0 || expDoneQ.size() != 0) begin
            errors++; $display("FAIL sb_drain: got grants=%0d dones=%0d pending want 0 0", expGrantQ.size(), expDoneQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
